sound_i2s_tx: RTL and testbench

- Downstream stage of the GLU audio path. Consumes the 16-bit signed stereo mix (post-volume, post-noise-gate) and serialises it as a standard Philips I2S stream to the external DAC.
- Bit clock comes from a fractional phase accumulator on the single logic clock. No second clock domain and no PLL.
- Latches L/R as a coherent pair once per frame and emits a one-cycle sample strobe that upstream logic may use for rate-aligned updates.

---
 rtl/sound_i2s_if.sv | 24 ++
 rtl/sound_i2s_tx.sv | 80 ++++++++
 tb/tb_sound_i2s_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_i2s_if.sv
// Stereo sample input and I2S output bundle for the GLU audio serialiser.
// The master side is the upstream mixer/controller; the slave side is the transmitter.
interface sound_i2s_if #(
    parameter int DATA_W = 16
);
    logic                     enable_i;
    logic                     mute_i;
    logic signed [DATA_W-1:0] audio_l_i;
    logic signed [DATA_W-1:0] audio_r_i;
    logic                     sample_req_o;
    logic                     i2s_bclk_o;
    logic                     i2s_lrclk_o;
    logic                     i2s_data_o;

    modport master (
        output enable_i, mute_i, audio_l_i, audio_r_i,
        input  sample_req_o, i2s_bclk_o, i2s_lrclk_o, i2s_data_o
    );

    modport slave (
        input  enable_i, mute_i, audio_l_i, audio_r_i,
        output sample_req_o, i2s_bclk_o, i2s_lrclk_o, i2s_data_o
    );
endinterface

// File: rtl/sound_i2s_tx.sv
// Philips I2S transmitter: 64 BCLK/frame, 16-bit samples left-justified after the one-bit delay.
// BCLK is derived from a fractional phase accumulator on the single logic clock.
module sound_i2s_tx #(
    parameter int CLK_FREQ    = 54_000_000,
    parameter int SAMPLE_RATE = 48_000,
    parameter int ACC_WIDTH   = 24,
    parameter int DATA_W      = 16
) (
    input  logic      clk_i,
    input  logic      reset_i,
    sound_i2s_if.slave bus
);
    // Two ticks per BCLK period, 64 BCLK per frame: 128 ticks per sample, rounded to nearest.
    localparam logic [63:0] PHASE_NUM   = (64'(128) * 64'(SAMPLE_RATE)) << ACC_WIDTH;
    localparam logic [63:0] PHASE_INC_W = (PHASE_NUM + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    localparam logic [ACC_WIDTH-1:0] PHASE_INC = PHASE_INC_W[ACC_WIDTH-1:0];
    localparam int IDX_W = $clog2(DATA_W);

    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     acc_sum;
    logic                     tick;
    logic                     bclk;
    logic                     lrclk;
    logic                     data;
    logic                     req;
    logic [5:0]               bit_cnt;
    logic [5:0]               cnt_inc;
    logic                     slot_data;
    logic signed [DATA_W-1:0] lat_l;
    logic signed [DATA_W-1:0] lat_r;

    function automatic logic slot_bit(input logic signed [DATA_W-1:0] s, input logic [4:0] k);
        logic [4:0] idx;
        idx = 5'(DATA_W) - k;
        if (k >= 5'd1 && k <= 5'(DATA_W))
            return s[idx[IDX_W-1:0]];
        return 1'b0;
    endfunction

    always_comb begin
        {tick, acc_sum} = {1'b0, acc} + {1'b0, PHASE_INC};
        cnt_inc   = bit_cnt + 6'd1;
        slot_data = slot_bit(cnt_inc[5] ? lat_r : lat_l, cnt_inc[4:0]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || !bus.enable_i) begin
            acc     <= '0;
            bclk    <= 1'b0;
            bit_cnt <= 6'd63;
            lrclk   <= 1'b1;
            data    <= 1'b0;
            req     <= 1'b0;
            lat_l   <= '0;
            lat_r   <= '0;
        end else begin
            acc <= acc_sum;
            req <= 1'b0;
            if (tick) begin
                bclk <= ~bclk;
                // Only the falling BCLK edge advances the slot; the DAC samples on the rising one.
                if (bclk) begin
                    bit_cnt <= cnt_inc;
                    lrclk   <= cnt_inc[5];
                    data    <= slot_data;
                    if (cnt_inc == 6'd0) begin
                        lat_l <= bus.mute_i ? '0 : bus.audio_l_i;
                        lat_r <= bus.mute_i ? '0 : bus.audio_r_i;
                        req   <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.sample_req_o = req;
    assign bus.i2s_bclk_o   = bclk;
    assign bus.i2s_lrclk_o  = lrclk;
    assign bus.i2s_data_o   = data;
endmodule

// File: tb/tb_sound_i2s_tx.sv
// Bench for sound_i2s_tx: directed stimulus, latch-time expectations queued, an I2S decoder pops and compares.
module tb_sound_i2s_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sound_i2s_if bus ();

    sound_i2s_tx dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_q[$];

    // Decoder / monitor state
    logic        prev_b = 1'b0;
    logic        prev_lr = 1'b1;
    logic        prev_tick = 1'b0;
    logic        in_frame = 1'b0;
    int          r = 0;
    int          pos = 0;
    logic [63:0] frame_bits;
    logic [63:0] frame_lr;
    int          frames_done = 0;
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;
    logic        fell = 1'b0;
    logic        req_now = 1'b0;
    logic        meas = 1'b0;
    int          fall_cnt = 0;
    int          req_cnt = 0;
    int          consec = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Expected pair: whatever the bench drove into the latch edge.
    always begin
        logic [31:0] cap;
        @(posedge clk);
        cap = bus.mute_i ? 32'h0 : {bus.audio_l_i, bus.audio_r_i};
        #1;
        if (bus.sample_req_o === 1'b1)
            exp_q.push_back(cap);
    end

    always begin
        logic b, lr, d, q, tk;
        logic [15:0] dl, dr;
        logic [31:0] e;
        @(posedge clk);
        #1;
        b  = bus.i2s_bclk_o;
        lr = bus.i2s_lrclk_o;
        d  = bus.i2s_data_o;
        q  = bus.sample_req_o;
        tk = (b != prev_b);
        fell    = prev_b && !b;
        req_now = q;
        if (meas) begin
            if (tk && prev_tick) consec++;
            if (fell) fall_cnt++;
            if (q) req_cnt++;
        end
        if (q) begin
            check("req_with_lrclk_fall", {prev_lr, lr}, 2'b10);
            if (in_frame && exp_q.size() > 0)
                void'(exp_q.pop_front());
            in_frame = 1'b1;
            r = 0;
            pos = 0;
        end else if (fell) begin
            pos++;
        end
        if (!prev_b && b && in_frame) begin
            frame_bits[r] = d;
            frame_lr[r]   = lr;
            r++;
            if (r == 64) begin
                in_frame = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    dl[15-i] = frame_bits[1+i];
                    dr[15-i] = frame_bits[33+i];
                end
                if (exp_q.size() == 0) begin
                    check("frame_expectation_present", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("left_word", 64'(dl), 64'(e[31:16]));
                    check("right_word", 64'(dr), 64'(e[15:0]));
                end
                check("slot_padding", frame_bits & ~64'h0001FFFE_0001FFFE, 64'h0);
                check("lrclk_pattern", frame_lr, 64'hFFFFFFFF_00000000);
                last_l = dl;
                last_r = dr;
                frames_done++;
            end
        end
        prev_tick = tk;
        prev_b    = b;
        prev_lr   = lr;
    end

    task automatic wait_frames(input int n);
        int target;
        target = frames_done + n;
        for (int i = 0; i < n * 1300 + 1200 && frames_done < target; i++) begin
            @(posedge clk);
            #2;
        end
        if (frames_done < target) check("frame_timeout", 64'(frames_done), 64'(target));
    endtask

    task automatic wait_pos(input int p);
        int ok;
        ok = 0;
        for (int i = 0; i < 2600 && ok == 0; i++) begin
            @(posedge clk);
            #2;
            if (in_frame && pos == p) ok = 1;
        end
        if (ok == 0) check("pos_timeout", 64'(pos), 64'(p));
    endtask

    task automatic wait_req();
        int ok;
        ok = 0;
        for (int i = 0; i < 2600 && ok == 0; i++) begin
            @(posedge clk);
            #2;
            if (req_now) ok = 1;
        end
        if (ok == 0) check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_fall_req(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            @(posedge clk);
            #2;
            if (fell) ok = 1;
        end
        check(name, {63'd0, req_now}, 64'd1);
        check("restart_left_first", {63'd0, bus.i2s_lrclk_o}, 64'd0);
    endtask

    task automatic check_idle(input string name);
        check(name, {60'd0, bus.i2s_bclk_o, bus.i2s_lrclk_o, bus.i2s_data_o, bus.sample_req_o}, 64'b0100);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable_i  = 1'b0;
        bus.mute_i    = 1'b0;
        bus.audio_l_i = 16'sh0000;
        bus.audio_r_i = 16'sh0000;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset_outputs");

        // Basic pattern: MSB/LSB set on left, inverted on right
        @(negedge clk);
        rst = 1'b0;
        bus.enable_i  = 1'b1;
        bus.audio_l_i = 16'sh8001;
        bus.audio_r_i = 16'sh7FFE;
        wait_frames(2);
        check("directed_left", 64'(last_l), 64'h8001);
        check("directed_right", 64'(last_r), 64'h7FFE);

        // Inputs changing every cycle: only the latch-cycle value is sent
        begin
            int target;
            target = frames_done + 3;
            for (int i = 0; i < 4500 && frames_done < target; i++) begin
                @(negedge clk);
                bus.audio_l_i = 16'(i * 3 + 1);
                bus.audio_r_i = 16'(16'hA5A5 ^ i);
            end
            if (frames_done < target) check("counter_timeout", 64'(frames_done), 64'(target));
        end

        // Mute asserted mid-left-slot affects only the following frame
        @(negedge clk);
        bus.audio_l_i = 16'sh1234;
        bus.audio_r_i = 16'sh5678;
        wait_req();
        wait_pos(20);
        @(negedge clk);
        bus.mute_i = 1'b1;
        wait_frames(1);
        check("mute_current_left", 64'(last_l), 64'h1234);
        check("mute_current_right", 64'(last_r), 64'h5678);
        wait_frames(1);
        check("mute_next_left", 64'(last_l), 64'h0);
        check("mute_next_right", 64'(last_r), 64'h0);
        @(negedge clk);
        bus.mute_i = 1'b0;

        // One-cycle reset at bit 40
        wait_pos(40);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_idle("reset_pulse_outputs");
        @(negedge clk);
        rst = 1'b0;
        wait_fall_req("reset_restart_latch");
        wait_frames(1);
        check("after_reset_left", 64'(last_l), 64'h1234);
        check("after_reset_right", 64'(last_r), 64'h5678);

        // Disable for 10 cycles in the right slot
        wait_pos(40);
        @(negedge clk);
        bus.enable_i  = 1'b0;
        bus.audio_l_i = 16'shC3A5;
        bus.audio_r_i = 16'sh0F0F;
        repeat (10) begin
            @(posedge clk);
            #2;
            check_idle("disabled_outputs");
        end
        @(negedge clk);
        bus.enable_i = 1'b1;
        wait_fall_req("enable_restart_latch");
        wait_frames(1);
        check("after_enable_left", 64'(last_l), 64'hC3A5);
        check("after_enable_right", 64'(last_r), 64'h0F0F);

        // Rate measurement over 50k cycles: 5688.9 ticks expected
        @(posedge clk);
        #2;
        meas = 1'b1;
        repeat (50_000) @(posedge clk);
        #2;
        meas = 1'b0;
        check_range("bclk_fall_count", fall_cnt, 2844, 2845);
        check_range("sample_req_count", req_cnt, 44, 45);
        check("consecutive_ticks", 64'(consec), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
